// File: rtl/ram_wb_arb_n_if.sv
`default_nettype none
// ============================================================================
// Interface : ram_wb_arb_n_if
// Brief     : Bus bundle for ram_wb_arb_n. Holds the packed master-side fields
//             (slice k belongs to master k) and the single RAM slave port.
//             Signal suffixes are from the arbiter's point of view.
//             Modport 'slave'  : arbiter side (answers the masters).
//             Modport 'master' : environment side (masters + RAM model).
// Revision  : 1.0 - initial release
// ============================================================================
interface ram_wb_arb_n_if #(
    parameter int DW          = 32,
    parameter int AW          = 32,
    parameter int NUM_MASTERS = 3
);
    // master side
    logic [NUM_MASTERS*AW-1:0]     wbm_adr_i;
    logic [NUM_MASTERS*DW-1:0]     wbm_dat_i;
    logic [NUM_MASTERS*DW/8-1:0]   wbm_sel_i;
    logic [NUM_MASTERS*3-1:0]      wbm_cti_i;
    logic [NUM_MASTERS*2-1:0]      wbm_bte_i;
    logic [NUM_MASTERS-1:0]        wbm_cyc_i;
    logic [NUM_MASTERS-1:0]        wbm_stb_i;
    logic [NUM_MASTERS-1:0]        wbm_we_i;
    logic [NUM_MASTERS-1:0]        wbm_ack_o;
    logic [NUM_MASTERS-1:0]        wbm_err_o;
    logic [NUM_MASTERS-1:0]        wbm_rty_o;
    logic [DW-1:0]                 wbm_dat_o;

    // slave (RAM) side
    logic [AW-1:0]                 wbs_adr_o;
    logic [DW-1:0]                 wbs_dat_o;
    logic [DW/8-1:0]               wbs_sel_o;
    logic [2:0]                    wbs_cti_o;
    logic [1:0]                    wbs_bte_o;
    logic                          wbs_cyc_o;
    logic                          wbs_stb_o;
    logic                          wbs_we_o;
    logic [DW-1:0]                 wbs_dat_i;
    logic                          wbs_ack_i;
    logic                          wbs_err_i;
    logic                          wbs_rty_i;

    modport slave (
        input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_cti_i, wbm_bte_i,
        input  wbm_cyc_i, wbm_stb_i, wbm_we_i,
        output wbm_ack_o, wbm_err_o, wbm_rty_o, wbm_dat_o,
        output wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_cti_o, wbs_bte_o,
        output wbs_cyc_o, wbs_stb_o, wbs_we_o,
        input  wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i
    );

    modport master (
        output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_cti_i, wbm_bte_i,
        output wbm_cyc_i, wbm_stb_i, wbm_we_i,
        input  wbm_ack_o, wbm_err_o, wbm_rty_o, wbm_dat_o,
        input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_cti_o, wbs_bte_o,
        input  wbs_cyc_o, wbs_stb_o, wbs_we_o,
        output wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i
    );
endinterface
`default_nettype wire

// File: rtl/ram_wb_arb_n.sv
`default_nettype none
// ============================================================================
// Module   : ram_wb_arb_n
// Brief    : Round-robin Wishbone arbiter connecting NUM_MASTERS masters to a
//            single RAM slave. Grant is registered and held for the whole cyc
//            assertion (bursts included); one idle cycle between owners.
//            Define RAM_WB_ARB_N_WATCHDOG_EN to add a stall watchdog that
//            errors the owner after TIMEOUT stalled strobe cycles.
// Revision : 1.0 - initial release
// ============================================================================
module ram_wb_arb_n #(
    parameter int DW          = 32,
    parameter int AW          = 32,
    parameter int NUM_MASTERS = 3,
    parameter int TIMEOUT     = 255
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_ni,
    ram_wb_arb_n_if.slave           bus,
    output logic [NUM_MASTERS-1:0]  grant_o
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int SW = DW / 8;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IW-1:0]          last_q,  last_d;   // most recently granted index

    logic                   w_busy;
    logic                   w_found;
    logic [IW-1:0]          w_cand;
    logic [IW-1:0]          w_pick_idx;
    logic                   w_timeout;

    logic [AW-1:0]          w_adr;
    logic [DW-1:0]          w_dat;
    logic [SW-1:0]          w_sel;
    logic [2:0]             w_cti;
    logic [1:0]             w_bte;
    logic                   w_cyc;
    logic                   w_stb;
    logic                   w_we;

    assign w_busy = (state_q == S_BUSY);

    // Round-robin search: first requester after last_q, wrapping around
    always_comb begin
        w_found    = 1'b0;
        w_cand     = '0;
        w_pick_idx = last_q;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            w_cand = IW'((int'(last_q) + i) % NUM_MASTERS);
            if (!w_found && bus.wbm_cyc_i[w_cand]) begin
                w_found    = 1'b1;
                w_pick_idx = w_cand;
            end
        end
    end

    // Arbiter next state: grant from IDLE, release when owner drops cyc
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (|bus.wbm_cyc_i) begin
                    state_d = S_BUSY;
                    grant_d = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << w_pick_idx;
                    last_d  = w_pick_idx;
                end
            end
            S_BUSY: begin
                if (!bus.wbm_cyc_i[last_q]) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Arbiter state registers; last resets so master 0 wins first
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= IW'(NUM_MASTERS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Slave request mux: owner's slice while busy, all-zero while idle
    always_comb begin
        w_adr = '0;
        w_dat = '0;
        w_sel = '0;
        w_cti = '0;
        w_bte = '0;
        w_cyc = 1'b0;
        w_stb = 1'b0;
        w_we  = 1'b0;
        if (w_busy) begin
            w_adr = bus.wbm_adr_i[int'(last_q)*AW +: AW];
            w_dat = bus.wbm_dat_i[int'(last_q)*DW +: DW];
            w_sel = bus.wbm_sel_i[int'(last_q)*SW +: SW];
            w_cti = bus.wbm_cti_i[int'(last_q)*3 +: 3];
            w_bte = bus.wbm_bte_i[int'(last_q)*2 +: 2];
            w_cyc = bus.wbm_cyc_i[last_q];
            w_stb = bus.wbm_stb_i[last_q];
            w_we  = bus.wbm_we_i[last_q];
        end
    end

`ifdef RAM_WB_ARB_N_WATCHDOG_EN
    logic [15:0] wd_q, wd_d;

    // Timeout fires while the stall count sits at the limit
    assign w_timeout = w_busy && (wd_q == 16'(TIMEOUT));

    // Stall counter: clears on response, timeout or leaving BUSY
    always_comb begin
        wd_d = wd_q;
        if ((state_d != S_BUSY) || w_timeout || bus.wbs_ack_i || bus.wbs_err_i) begin
            wd_d = '0;
        end else if (w_stb) begin
            wd_d = wd_q + 16'd1;
        end
    end

    // Stall counter register
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Retry is never passed on; TIMEOUT only matters with the watchdog
    logic w_unused;
    assign w_unused = bus.wbs_rty_i ^ (TIMEOUT == 0);

    assign bus.wbs_adr_o = w_adr;
    assign bus.wbs_dat_o = w_dat;
    assign bus.wbs_sel_o = w_sel;
    assign bus.wbs_cti_o = w_cti;
    assign bus.wbs_bte_o = w_bte;
    assign bus.wbs_cyc_o = w_cyc;
    assign bus.wbs_stb_o = w_stb & ~w_timeout;
    assign bus.wbs_we_o  = w_we;

    // Responses only reach the owner; idle-time responses vanish
    assign bus.wbm_ack_o = grant_q & {NUM_MASTERS{bus.wbs_ack_i}};
    assign bus.wbm_err_o = grant_q & {NUM_MASTERS{bus.wbs_err_i | w_timeout}};
    assign bus.wbm_rty_o = '0;
    assign bus.wbm_dat_o = bus.wbs_dat_i;

    assign grant_o = grant_q;

endmodule
`default_nettype wire
